// File: rtl/output_argmax_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : output_argmax_reader_if
// Brief    : Score-bus / result handshake bundle for output_argmax_reader.
// Revision : 1.0  initial release
// ============================================================================
interface output_argmax_reader_if #(
  parameter int neuron_number = 10,
  parameter int dataWidth     = 16
) ();
  localparam int SW = 2 * dataWidth;
  localparam int IW = (neuron_number > 1) ? $clog2(neuron_number) : 1;

  logic                      start;
  logic [SW*neuron_number-1:0] scores_in;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [IW-1:0]             class_idx;
  logic [SW-1:0]             class_score;

  modport master (
    output start, scores_in, out_ready,
    input  busy, out_valid, class_idx, class_score
  );

  modport slave (
    input  start, scores_in, out_ready,
    output busy, out_valid, class_idx, class_score
  );
endinterface
`default_nettype wire

// File: rtl/output_argmax_reader.sv
`default_nettype none
// ============================================================================
// Module   : output_argmax_reader
// Brief    : Snapshots the final layer's packed scores on start, scans one slot
//            per cycle and returns the argmax index/score over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module output_argmax_reader #(
  parameter int neuron_number = 10,
  parameter int dataWidth     = 16
) (
  input logic                   clk,
  input logic                   rst,
  output_argmax_reader_if.slave bus
);
  localparam int SW = 2 * dataWidth;
  localparam int IW = (neuron_number > 1) ? $clog2(neuron_number) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(neuron_number - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [SW*neuron_number-1:0] shadow_q, shadow_d;
  logic signed [SW-1:0]        best_q, best_d;
  logic [IW-1:0]               best_idx_q, best_idx_d;
  logic [IW-1:0]               cnt_q, cnt_d;
  logic                        valid_q, valid_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [SW-1:0]               score_q, score_d;

  logic signed [SW-1:0]        slot_w;
  logic                        take_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    score_d    = score_q;

    // Strict signed compare: on a tie the earlier (lower) index is kept.
    slot_w = shadow_q[int'(cnt_q)*SW +: SW];
    take_w = (slot_w > best_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shadow_d   = bus.scores_in;
          best_d     = bus.scores_in[SW-1:0];
          best_idx_d = '0;
          cnt_d      = IW'(1);
          if (neuron_number == 1) begin
            state_d = HOLD;
            valid_d = 1'b1;
            idx_d   = '0;
            score_d = bus.scores_in[SW-1:0];
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (take_w) begin
          best_d     = slot_w;
          best_idx_d = cnt_q;
        end
        // Publish the last comparison directly so results register on entry to HOLD.
        if (cnt_q == LAST_IDX) begin
          state_d = HOLD;
          valid_d = 1'b1;
          idx_d   = take_w ? cnt_q : best_idx_q;
          score_d = take_w ? slot_w : best_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = valid_q;
  assign bus.class_idx   = idx_q;
  assign bus.class_score = score_q;

endmodule
`default_nettype wire

// File: tb/tb_output_argmax_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_argmax_reader
// Brief    : Directed self-checking bench for output_argmax_reader (N=10, dW=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_output_argmax_reader;
  logic clk;
  logic rst;
  logic [319:0] vec;
  int n_tests;
  int n_fail;

  output_argmax_reader_if #(.neuron_number(10), .dataWidth(16)) bus ();

  output_argmax_reader #(.neuron_number(10), .dataWidth(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the caller at the negedge just after the start edge.
  task automatic do_start(input logic [319:0] s);
    bus.scores_in = s;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Counts edges after the start edge until out_valid; optionally scrambles scores_in.
  task automatic wait_valid(input string tag, input bit scramble);
    int n;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      if (scramble)
        for (int w = 0; w < 10; w++) bus.scores_in[w*32 +: 32] = $urandom;
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n), 64'd9);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    bus.scores_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_idx",   64'(bus.class_idx), 64'd0);
    chk("rst_score", 64'(bus.class_score), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single positive slot
    vec = '0;
    vec[7*32 +: 32] = 32'h0000_0100;
    do_start(vec);
    chk("t1_busy_scan", 64'(bus.busy), 64'd1);
    wait_valid("t1_latency", 1'b0);
    chk("t1_idx",   64'(bus.class_idx), 64'd7);
    chk("t1_score", 64'(bus.class_score), 64'h100);
    @(negedge clk);
    chk("t1_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("t1_busy_idle",  64'(bus.busy), 64'd0);
    chk("t1_idx_hold",   64'(bus.class_idx), 64'd7);

    // 2: all negative, signed compare
    for (int i = 0; i < 10; i++) vec[i*32 +: 32] = -(i + 1);
    do_start(vec);
    wait_valid("t2_latency", 1'b0);
    chk("t2_idx",   64'(bus.class_idx), 64'd0);
    chk("t2_score", 64'(bus.class_score), 64'hFFFF_FFFF);
    @(negedge clk);

    // 3: tie keeps lower index, most-negative slot ignored
    vec = '0;
    vec[3*32 +: 32] = 32'd500;
    vec[8*32 +: 32] = 32'd500;
    vec[9*32 +: 32] = 32'h8000_0000;
    do_start(vec);
    wait_valid("t3_latency", 1'b0);
    chk("t3_idx",   64'(bus.class_idx), 64'd3);
    chk("t3_score", 64'(bus.class_score), 64'd500);
    @(negedge clk);

    // 4: backpressure with start pulses and scores changes during HOLD
    bus.out_ready = 1'b0;
    vec = '0;
    vec[5*32 +: 32] = 32'd1000;
    do_start(vec);
    wait_valid("t4_latency", 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.start = 1'b1;
      vec = '1;
      vec[9*32 +: 32] = 32'h7FFF_FFFF;
      bus.scores_in = vec;
      @(negedge clk);
      chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("t4_hold_busy",  64'(bus.busy), 64'd1);
      chk("t4_hold_idx",   64'(bus.class_idx), 64'd5);
      chk("t4_hold_score", 64'(bus.class_score), 64'd1000);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("t4_busy_idle",  64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("t4_start_ignored", 64'(bus.busy), 64'd0);

    // 5: reset mid-scan at cnt=4
    vec = '0;
    vec[2*32 +: 32] = 32'd77;
    do_start(vec);
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy",  64'(bus.busy), 64'd0);
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_idx",   64'(bus.class_idx), 64'd0);
    chk("t5_score", 64'(bus.class_score), 64'd0);
    @(negedge clk);
    do_start(vec);
    wait_valid("t5_latency", 1'b0);
    chk("t5_new_idx",   64'(bus.class_idx), 64'd2);
    chk("t5_new_score", 64'(bus.class_score), 64'd77);
    @(negedge clk);

    // 6: scores change after the start edge, then back-to-back start
    for (int i = 0; i < 10; i++) vec[i*32 +: 32] = -(i + 100);
    vec[2*32 +: 32] = 32'h1234_5678;
    do_start(vec);
    wait_valid("t6_latency", 1'b1);
    chk("t6_idx",   64'(bus.class_idx), 64'd2);
    chk("t6_score", 64'(bus.class_score), 64'h1234_5678);
    @(negedge clk);
    chk("t6_valid_drop", 64'(bus.out_valid), 64'd0);
    vec = '0;
    vec[9*32 +: 32] = 32'd1;
    do_start(vec);
    chk("t6_b2b_busy", 64'(bus.busy), 64'd1);
    wait_valid("t6_b2b_latency", 1'b0);
    chk("t6_b2b_idx",   64'(bus.class_idx), 64'd9);
    chk("t6_b2b_score", 64'(bus.class_score), 64'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
